// File: rtl/log2_pwl_interp_if.sv
// Streaming sample interface for the log2 piecewise-linear evaluator.
// Carries the input handshake (i_valid/o_ready/i_x) and the output
// handshake (o_valid/i_ready/o_y).
//   master : the side that supplies samples and consumes results
//   slave  : the evaluator itself
interface log2_pwl_interp_if #(
  parameter int BW_X = 8,
  parameter int BW_W = 10
);
  logic            i_valid;
  logic            o_ready;
  logic [BW_X-1:0] i_x;
  logic            o_valid;
  logic            i_ready;
  logic [BW_W-1:0] o_y;

  modport master (
    output i_valid, i_x, i_ready,
    input  o_ready, o_valid, o_y
  );

  modport slave (
    input  i_valid, i_x, i_ready,
    output o_ready, o_valid, o_y
  );
endinterface

// File: rtl/log2_pwl_interp.sv
// Piecewise-linear function evaluator on a log2-spaced knot grid
// (knots at x = 2^k, k = 0..BW_X), three-stage pipeline with
// valid/ready flow control and a runtime-programmable knot table.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset (clears pipe and table)
//   bus          sample stream (slave side): i_valid/o_ready/i_x in,
//                o_valid/i_ready/o_y out
//   i_cfg_we     knot table write enable
//   i_cfg_addr   knot index; indices above BW_X are ignored
//   i_cfg_wdata  knot value
module log2_pwl_interp #(
  parameter int BW_X = 8,
  parameter int BW_W = 10,
  parameter int BW_A = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  log2_pwl_interp_if.slave       bus,
  input  logic                   i_cfg_we,
  input  logic [BW_A-1:0]        i_cfg_addr,
  input  logic [BW_W-1:0]        i_cfg_wdata
);

  localparam int IW = $clog2(BW_X + 1);
  localparam int PW = BW_W + BW_X;
  localparam int SW = PW + 1;
  localparam logic [BW_A-1:0] ADDR_MAX = BW_A'(BW_X);

  logic [BW_W-1:0] tbl [0:BW_X];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j <= BW_X; j++) tbl[j] <= '0;
    end else if (i_cfg_we && (i_cfg_addr <= ADDR_MAX)) begin
      tbl[IW'(i_cfg_addr)] <= i_cfg_wdata;
    end
  end

  // Flow control: a stage moves when it is empty or its successor moves.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3        = !v3 || bus.i_ready;
  assign adv2        = !v2 || adv3;
  assign adv1        = !v1 || adv2;
  assign bus.o_ready = adv1;
  assign bus.o_valid = v3;

  // Segment select. x == 0 falls out as k = 0, f = 0, which yields T[0]
  // through the regular datapath, so it needs no special case.
  logic [IW-1:0]   k_in;
  logic [BW_X-1:0] pow_in;
  logic [BW_X-1:0] f_in;

  always_comb begin
    k_in = '0;
    for (int i = 0; i < BW_X; i++) begin
      if (bus.i_x[i]) k_in = IW'(i);
    end
    pow_in = BW_X'(1) << k_in;
    f_in   = bus.i_x & ~pow_in;
  end

  // S1: segment index, fraction and the two knots bracketing it.
  // The table is read in the accept cycle, so a same-edge write is not seen.
  logic [IW-1:0]   k1;
  logic [BW_X-1:0] f1;
  logic [BW_W-1:0] tlo1, thi1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      k1   <= '0;
      f1   <= '0;
      tlo1 <= '0;
      thi1 <= '0;
    end else if (adv1) begin
      v1 <= bus.i_valid;
      if (bus.i_valid) begin
        k1   <= k_in;
        f1   <= f_in;
        tlo1 <= tbl[k_in];
        thi1 <= tbl[k_in + IW'(1)];
      end
    end
  end

  // S2: weighted knot products. 2^k - f never exceeds 2^(BW_X-1).
  logic [BW_X-1:0] w_lo;
  logic [IW-1:0]   k2;
  logic [PW-1:0]   plo2, phi2;

  assign w_lo = (BW_X'(1) << k1) - f1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      k2   <= '0;
      plo2 <= '0;
      phi2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        k2   <= k1;
        plo2 <= PW'(tlo1) * PW'(w_lo);
        phi2 <= PW'(thi1) * PW'(f1);
      end
    end
  end

  // S3: round half up, renormalise by 2^k. The sum is a convex
  // combination of two BW_W-bit knots, so truncation loses nothing.
  logic [SW-1:0]   rnd;
  logic [SW-1:0]   sum;
  logic [BW_W-1:0] y_next;
  logic [BW_W-1:0] y3;

  always_comb begin
    rnd    = (k2 == '0) ? '0 : (SW'(1) << (k2 - IW'(1)));
    sum    = SW'(plo2) + SW'(phi2) + rnd;
    y_next = BW_W'(sum >> k2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      y3 <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) y3 <= y_next;
    end
  end

  assign bus.o_y = y3;

endmodule

// File: doc/log2_pwl_interp.md
Name: log2_pwl_interp

Overview:
- Streaming piecewise-linear function evaluator on a log2-spaced knot grid: knots at x = 2^k, k = 0..BW_X.
- Segment is selected by the MSB position of the input; interpolation is properly normalised and rounded.
- Knot table is runtime-programmable through a config write port.
- Sits in the 2D interpolator datapath as the parametrised successor of the fixed 8-knot linear interpolator. Adds valid/ready flow control and a 3-stage pipeline.

Parameters:
- BW_X, 8, input sample width; segment count = BW_X, table depth = BW_X+1.
- BW_W, 10, knot value and output width (unsigned).
- BW_A, 4, config address width; must satisfy 2^BW_A >= BW_X+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept a sample this cycle
- i_x  in  BW_X  unsigned input sample
- o_valid  out  1  output sample valid
- i_ready  in  1  downstream accepts output
- o_y  out  BW_W  interpolated result
- i_cfg_we  in  1  knot table write enable
- i_cfg_addr  in  BW_A  knot index
- i_cfg_wdata  in  BW_W  knot value

Behaviour:
- Reset: rst_n is sampled on the rising edge of clk.
  - While low: all stage valids = 0, o_valid = 0, o_y = 0, all table entries T[0..BW_X] = 0.
  - Reset mid-stream discards every in-flight sample with no output.
  - The first accept is possible on the first edge after rst_n goes high.
- Table write: on an edge with i_cfg_we=1 and i_cfg_addr <= BW_X, T[addr] <= wdata.
  - Addresses > BW_X are ignored.
  - Writes are never blocked by backpressure.
- Math, per sample x:
  - If x == 0: y = T[0].
  - Otherwise k = index of the highest set bit of x (0..BW_X-1), f = x - 2^k (k bits, 0 <= f < 2^k).
  - y = (T[k]*(2^k - f) + T[k+1]*f + R) >> k, where R = 2^(k-1) for k >= 1 and R = 0 for k = 0. This is round-half-up.
  - Products are BW_W+BW_X bits; the sum is BW_W+BW_X+1 bits.
  - The result is a convex combination, so it always fits BW_W with no saturation. Truncate to BW_W after the shift.
- Pipeline, each stage with its own valid bit:
  - S1 (accept): register k, f, T[k], T[k+1]. The table is read combinationally in the accept cycle.
  - S2: register both products.
  - S3: register the rounded, shifted sum into o_y, and set o_valid.
  - Latency: 3 cycles from accept edge to o_valid, assuming no backpressure.
- Handshake:
  - A sample is accepted on an edge with i_valid && o_ready.
  - An output is consumed on an edge with o_valid && i_ready.
  - Stage s advances when it is empty or stage s+1 advances; S3 advances when !o_valid || i_ready.
  - o_ready = S1 advances, a combinational path from i_ready. Bubbles collapse.
  - Throughput: 1 sample/cycle.
  - While o_valid && !i_ready: o_y holds stable, and no sample is dropped or duplicated.
- Simultaneous write and accept on the same edge: the accepted sample uses the old T value. The next accepted sample sees the new value.
- Samples already past S1 are unaffected by later table writes.
- o_y holds its last value when o_valid = 0.

Test Plan:
- Program T[j] = 100*j (j = 0..8), no backpressure; stream x = 0, 1, 2, 3, 192, 255 -> o_y = 0, 0, 100, 150, 750, 799. Each output 3 cycles after its accept.
- Rounding: T[1]=100, T[2]=201, x=3 -> o_y = 151. T[7]=0, T[8]=1, x=192 -> (64+64)>>7 = 1.
- Backpressure: 10 back-to-back samples, i_ready low for cycles 4-8.
  - o_ready drops once the pipe is full.
  - o_y is stable while stalled.
  - All 10 results arrive in order, none lost or duplicated.
- Write/accept collision: T[1]=100, then write T[1]=500 on the same edge that x=2 is accepted -> o_y = 100. Next x=2 -> 500. Write to addr 12 -> table unchanged.
- Reset mid-stream: 3 samples in flight, pull rst_n low for 1 cycle.
  - o_valid = 0 and o_y = 0 on the next edge; no stale outputs afterwards.
  - T reads back 0: x = 2 -> o_y = 0.
- Parameter sweep: BW_X=12, BW_W=16, random table and random x with random i_ready; compare against the reference model using the formula above. x = 4095 uses T[11] and T[12].
